// File: rtl/apb_master_if.sv
// apb_master_if: APB bus between the bridge and its four slaves
interface apb_master_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL0, PSEL1, PSEL2, PSEL3;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic        PREADY0, PREADY1, PREADY2, PREADY3;
  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY0, PREADY1, PREADY2, PREADY3
  );
  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL0, PSEL1, PSEL2, PSEL3,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY0, PREADY1, PREADY2, PREADY3
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: CPU load/store to APB bridge with 4-slave decode, timeout and unmapped-address errors
module apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  apb_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [1:0] sel;
  logic unmapped;
  logic [CW-1:0] cnt;
  logic sel_rdy, last, active;
  logic [31:0] sel_data;
  assign sel_rdy  = sel == 2'd0 ? bus.PREADY0 : sel == 2'd1 ? bus.PREADY1 : sel == 2'd2 ? bus.PREADY2 : bus.PREADY3;
  assign sel_data = sel == 2'd0 ? bus.PRDATA0 : sel == 2'd1 ? bus.PRDATA1 : sel == 2'd2 ? bus.PRDATA2 : bus.PRDATA3;
  assign last     = cnt == CW'(TIMEOUT - 1);
  assign active   = state != IDLE && !unmapped;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else state <= state_nx;
  end
  // request capture in IDLE; the wait counter only advances while ACCESS is unresolved
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.PADDR  <= '0;
      bus.PWDATA <= '0;
      bus.PWRITE <= 1'b0;
      sel        <= 2'd0;
      unmapped   <= 1'b0;
      cnt        <= '0;
    end else if (state == IDLE && transfer) begin
      bus.PADDR  <= addr;
      bus.PWDATA <= wdata;
      bus.PWRITE <= write;
      sel        <= addr[13:12];
      unmapped   <= addr[31:16] != 16'h1000 || addr[15:14] != 2'b00;
      cnt        <= '0;
    end else if (state == ACCESS && !ready) begin
      cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (transfer ? SETUP : IDLE) : state == SETUP ? ACCESS : ready ? IDLE : ACCESS;
  end
  always_comb begin
    bus.PENABLE = state == ACCESS;
    bus.PSEL0   = active && sel == 2'd0;
    bus.PSEL1   = active && sel == 2'd1;
    bus.PSEL2   = active && sel == 2'd2;
    bus.PSEL3   = active && sel == 2'd3;
    ready       = state == ACCESS && (unmapped || sel_rdy || last);
    err         = ready && (unmapped || !sel_rdy);
    rdata       = (!ready || unmapped) ? 32'h0 : sel_rdy ? (bus.PWRITE ? 32'h0 : sel_data) : 32'hDEAD_BEEF;
  end
endmodule
